ram_dma: RTL and testbench

RAM_DMA -- requirements
Module: ram_dma

---
 rtl/ram_dma_pkg.sv | 25 ++
 rtl/ram_dma.sv | 177 +++++++++++++++++
 tb/tb_ram_dma.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the word-oriented RAM DMA engine.
package ram_dma_pkg;

    // Engine states: read request, read-data wait, write, completion pulse.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } ram_dma_state_e;

    // Transfer kind selected by mode_i at start.
    typedef enum logic {
        DmaCopy = 1'b0,
        DmaFill = 1'b1
    } ram_dma_mode_e;

    // Byte stride between consecutive words.
    localparam logic [31:0] WordBytes = 32'd4;

    // All byte lanes enabled for every access.
    localparam logic [3:0] BeAll = 4'hF;

endpackage

// File: rtl/ram_dma.sv
// Word DMA engine: copies len words src->dst (read, wait, write per word)
// or fills len words at dst with a constant. The memory port accepts every
// request and answers reads exactly one cycle later.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int Width = 32,
    parameter int LenW  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              abort_i,
    input  logic [31:0]       src_addr_i,
    input  logic [31:0]       dst_addr_i,
    input  logic [LenW-1:0]   len_i,
    input  logic [Width-1:0]  fill_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LenW-1:0]   words_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_addr_o,
    output logic [Width-1:0]  mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [Width-1:0]  mem_rdata_i
);

    ram_dma_state_e   state_r, state_s;
    ram_dma_mode_e    mode_r, mode_s;
    logic [31:0]      src_r, src_s;
    logic [31:0]      dst_r, dst_s;
    logic [LenW-1:0]  len_r, len_s;
    logic [Width-1:0] fill_r, fill_s;
    logic [Width-1:0] data_r, data_s;
    logic [LenW-1:0]  words_r, words_s;
    logic             err_r, err_s;

    // Next-state, datapath updates and memory-port drive. The memory request
    // depends on abort_i combinationally so an abort cancels the access in
    // the same cycle it is raised.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        src_s       = src_r;
        dst_s       = dst_r;
        len_s       = len_r;
        fill_s      = fill_r;
        data_s      = data_r;
        words_s     = words_r;
        err_s       = err_r;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = {Width{1'b0}};

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    mode_s  = ram_dma_mode_e'(mode_i);
                    src_s   = src_addr_i;
                    dst_s   = dst_addr_i;
                    len_s   = len_i;
                    fill_s  = fill_data_i;
                    words_s = {LenW{1'b0}};
                    err_s   = 1'b0;
                    if (len_i == {LenW{1'b0}}) begin
                        state_s = DONE;
                    end else if (ram_dma_mode_e'(mode_i) == DmaFill) begin
                        state_s = WR;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            RD: begin
                if (abort_i) begin
                    state_s = DONE;
                end else begin
                    mem_req_o  = 1'b1;
                    mem_be_o   = BeAll;
                    mem_addr_o = src_r;
                    state_s    = WAIT;
                end
            end

            WAIT: begin
                if (abort_i) begin
                    state_s = DONE;
                end else if (mem_rvalid_i) begin
                    data_s  = mem_rdata_i;
                    state_s = WR;
                end else begin
                    // Missing read data is a port fault: flag it and stop.
                    err_s   = 1'b1;
                    state_s = DONE;
                end
            end

            WR: begin
                if (abort_i) begin
                    state_s = DONE;
                end else begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_be_o    = BeAll;
                    mem_addr_o  = dst_r;
                    mem_wdata_o = (mode_r == DmaFill) ? fill_r : data_r;
                    words_s     = words_r + LenW'(1);
                    // 32-bit wrap-around is intended; no overflow error.
                    dst_s       = dst_r + WordBytes;
                    if (mode_r == DmaCopy) begin
                        src_s = src_r + WordBytes;
                    end else begin
                        src_s = src_r;
                    end
                    if (words_s == len_r) begin
                        state_s = DONE;
                    end else if (mode_r == DmaFill) begin
                        state_s = WR;
                    end else begin
                        state_s = RD;
                    end
                end
            end

            DONE: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, command and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            mode_r  <= DmaCopy;
            src_r   <= 32'h0;
            dst_r   <= 32'h0;
            len_r   <= {LenW{1'b0}};
            fill_r  <= {Width{1'b0}};
            data_r  <= {Width{1'b0}};
            words_r <= {LenW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            len_r   <= len_s;
            fill_r  <= fill_s;
            data_r  <= data_s;
            words_r <= words_s;
            err_r   <= err_s;
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        busy_o  = (state_r != IDLE);
        done_o  = (state_r == DONE);
        err_o   = err_r;
        words_o = words_r;
    end

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma with a 1-cycle-latency RAM model and a
// transfer-level reference model (sequential word copy / fill semantics).
module tb_ram_dma;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, mode_i, abort_i;
    logic [31:0] src_addr_i, dst_addr_i, fill_data_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, err_o;
    logic [15:0] words_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        ram_rvalid = 1'b0;
    logic [31:0] ram_rdata = 32'h0;
    logic        stray_rvalid = 1'b0;
    logic [31:0] stray_data = 32'h0;
    bit   [31:0] mem [bit [31:0]];
    int          drop_read = -1;
    int          rd_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wr_addr_q[$], wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] exp_addr_q[$], exp_data_q[$];
    int          exp_cyc_q[$];
    int          exp_done, done_cyc, last_req, inv_bad, done_words;
    logic        done_err;
    bit          post_ok;

    assign mem_rvalid_i = ram_rvalid | stray_rvalid;
    assign mem_rdata_i  = stray_rvalid ? stray_data : ram_rdata;

    always #5 clk_i = ~clk_i;

    ram_dma #(.Width(32), .LenW(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .abort_i(abort_i), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
        .len_i(len_i), .fill_data_i(fill_data_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .words_o(words_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // RAM read port: data one cycle after a read request, optionally withheld.
    always @(posedge clk_i) begin
        if (mem_req_o && !mem_we_o && rd_cnt != drop_read) begin
            ram_rvalid <= 1'b1;
            ram_rdata  <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
        end else begin
            ram_rvalid <= 1'b0;
            ram_rdata  <= 32'h0;
        end
        if (start_i) rd_cnt <= 0;
        else if (mem_req_o && !mem_we_o) rd_cnt <= rd_cnt + 1;
    end

    // Reference model: transfer semantics on a snapshot of memory.
    task automatic model_cmd(input bit mode, input logic [31:0] src, input logic [31:0] dst,
                             input int len, input logic [31:0] fill);
        bit [31:0] mm [bit [31:0]];
        logic [31:0] a, s, d;
        mm = mem;
        exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
        for (int i = 0; i < len; i++) begin
            a = dst + 32'(4 * i);
            s = src + 32'(4 * i);
            d = (mode == 1'b1) ? fill : (mm.exists(s) ? mm[s] : 32'h0);
            mm[a] = d;
            exp_addr_q.push_back(a);
            exp_data_q.push_back(d);
            exp_cyc_q.push_back(mode ? (i + 1) : 3 * (i + 1));
        end
        exp_done = (len == 0) ? 1 : (mode ? len + 1 : 3 * len + 1);
    endtask

    task automatic preload(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) mem[base + 32'(4 * i)] = $urandom;
    endtask

    // Issue one command, act as RAM write port, record writes and invariants.
    task automatic run_cmd(input bit mode, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input logic [31:0] fill,
                           input int abort_cyc, input int restart_cyc);
        int cyc;
        int budget;
        budget = 3 * len + 10;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_cyc = -1; last_req = 0; inv_bad = 0; done_words = -1; done_err = 1'bx;
        @(negedge clk_i);
        mode_i = mode; src_addr_i = src; dst_addr_i = dst;
        len_i = 16'(len); fill_data_i = fill; start_i = 1'b1;
        @(posedge clk_i);
        cyc = 1;
        while (cyc <= budget) begin
            @(negedge clk_i);
            start_i = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                src_addr_i = $urandom; dst_addr_i = $urandom;
                len_i = 16'($urandom_range(1, 50)); fill_data_i = $urandom; mode_i = ~mode;
            end
            abort_i = (cyc == abort_cyc);
            #1;
            if (busy_o !== 1'b1) inv_bad++;
            if (mem_req_o === 1'b1) begin
                last_req = cyc;
                if (mem_be_o !== 4'hF) inv_bad++;
                if (mem_we_o === 1'b1) begin
                    wr_addr_q.push_back(mem_addr_o);
                    wr_data_q.push_back(mem_wdata_o);
                    wr_cyc_q.push_back(cyc);
                    mem[mem_addr_o] = mem_wdata_o;
                end
            end else if (mem_we_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
                inv_bad++;
            end
            if (done_o === 1'b1) begin
                done_cyc = cyc; done_words = int'(words_o); done_err = err_o;
                break;
            end
            cyc++;
        end
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        #1;
        post_ok = (done_o === 1'b0 && busy_o === 1'b0 && mem_req_o === 1'b0);
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; abort_i = 1'b0;
        src_addr_i = 32'h0; dst_addr_i = 32'h0; len_i = 16'h0; fill_data_i = 32'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, words_o} !== 19'h0) begin
            n_bad++; $display("FAIL reset_status: got %h expected 0", {busy_o, done_o, err_o, words_o});
        end
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 70'h0) begin
            n_bad++; $display("FAIL reset_mem: req=%b addr=%h expected all 0", mem_req_o, mem_addr_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_copy;
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA000_00A0 + 32'(i);
        model_cmd(1'b0, 32'h100, 32'h200, 4, 32'h0);
        run_cmd(1'b0, 32'h100, 32'h200, 4, 32'h0, 0, 0);
        n_cmp++;
        if (done_cyc !== 13) begin n_bad++; $display("FAIL copy_done_cyc: got %0d expected 13", done_cyc); end
        n_cmp++;
        if (done_words !== 4 || done_err !== 1'b0) begin
            n_bad++; $display("FAIL copy_status: words=%0d err=%b expected 4/0", done_words, done_err);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[32'h200 + 32'(4 * i)] !== 32'hA000_00A0 + 32'(i)) begin
                n_bad++; $display("FAIL copy_ram[%0d]: got %h expected %h", i,
                                  mem[32'h200 + 32'(4 * i)], 32'hA000_00A0 + 32'(i));
            end
        end
        // Randomized copies, source and destination may overlap.
        for (int t = 0; t < 6; t++) begin
            logic [31:0] s, d;
            int len;
            len = $urandom_range(1, 8);
            s = 32'h1000 + 32'(4 * $urandom_range(0, 31));
            d = 32'h1000 + 32'(4 * $urandom_range(0, 31));
            preload(s, len);
            model_cmd(1'b0, s, d, len, 32'h0);
            run_cmd(1'b0, s, d, len, 32'h0, 0, 0);
            n_cmp++;
            if (done_cyc !== exp_done || done_words !== len || done_err !== 1'b0 || inv_bad !== 0 || !post_ok) begin
                n_bad++; $display("FAIL rcopy_status[%0d]: done=%0d words=%0d err=%b inv=%0d post=%b expected %0d/%0d/0/0/1",
                                  t, done_cyc, done_words, done_err, inv_bad, post_ok, exp_done, len);
            end
            n_cmp++;
            if (wr_addr_q != exp_addr_q || wr_data_q != exp_data_q || wr_cyc_q != exp_cyc_q) begin
                n_bad++; $display("FAIL rcopy_writes[%0d]: got %0d writes, first %h expected %0d writes, first %h",
                                  t, wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0,
                                  exp_addr_q.size(), exp_data_q[0]);
            end
        end
    endtask

    task automatic test_fill;
        model_cmd(1'b1, 32'h0, 32'h40, 3, 32'hDEAD_BEEF);
        run_cmd(1'b1, 32'h0, 32'h40, 3, 32'hDEAD_BEEF, 0, 0);
        n_cmp++;
        if (done_cyc !== 4 || done_words !== 3) begin
            n_bad++; $display("FAIL fill_done: cyc=%0d words=%0d expected 4/3", done_cyc, done_words);
        end
        n_cmp++;
        if (wr_addr_q != exp_addr_q || wr_data_q != exp_data_q || wr_cyc_q != exp_cyc_q) begin
            n_bad++; $display("FAIL fill_writes: got %0d writes expected %0d", wr_addr_q.size(), exp_addr_q.size());
        end
        // Random fills with a stray rvalid held high throughout (must be ignored).
        for (int t = 0; t < 4; t++) begin
            logic [31:0] d, f;
            int len;
            len = $urandom_range(1, 12);
            d = $urandom & 32'hFFFF_FFFC;
            f = $urandom;
            stray_data = ~f;
            stray_rvalid = 1'b1;
            model_cmd(1'b1, 32'h0, d, len, f);
            run_cmd(1'b1, $urandom, d, len, f, 0, 0);
            stray_rvalid = 1'b0;
            n_cmp++;
            if (done_cyc !== exp_done || done_words !== len || inv_bad !== 0 || !post_ok) begin
                n_bad++; $display("FAIL rfill_status[%0d]: done=%0d words=%0d inv=%0d expected %0d/%0d/0",
                                  t, done_cyc, done_words, inv_bad, exp_done, len);
            end
            n_cmp++;
            if (wr_addr_q != exp_addr_q || wr_data_q != exp_data_q || wr_cyc_q != exp_cyc_q) begin
                n_bad++; $display("FAIL rfill_writes[%0d]: got %0d writes expected %0d", t,
                                  wr_addr_q.size(), exp_addr_q.size());
            end
        end
    endtask

    task automatic test_len_zero;
        run_cmd(1'b0, 32'h100, 32'h200, 0, 32'h0, 0, 0);
        n_cmp++;
        if (done_cyc !== 1 || last_req !== 0 || inv_bad !== 0 || !post_ok) begin
            n_bad++; $display("FAIL len0: done=%0d last_req=%0d inv=%0d post=%b expected 1/0/0/1",
                              done_cyc, last_req, inv_bad, post_ok);
        end
    endtask

    task automatic test_wrap;
        preload(32'h300, 2);
        model_cmd(1'b0, 32'h300, 32'hFFFF_FFFC, 2, 32'h0);
        run_cmd(1'b0, 32'h300, 32'hFFFF_FFFC, 2, 32'h0, 0, 0);
        n_cmp++;
        if (wr_addr_q.size() !== 2 || wr_addr_q[0] !== 32'hFFFF_FFFC || wr_addr_q[1] !== 32'h0) begin
            n_bad++; $display("FAIL wrap_addr: got %0d writes, %h %h expected fffffffc 00000000",
                              wr_addr_q.size(), wr_addr_q[0], (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hx);
        end
        n_cmp++;
        if (wr_data_q != exp_data_q || done_err !== 1'b0 || done_cyc !== 7) begin
            n_bad++; $display("FAIL wrap_status: err=%b done=%0d expected 0/7", done_err, done_cyc);
        end
    endtask

    task automatic test_rvalid_error;
        preload(32'h400, 3);
        drop_read = 1;
        run_cmd(1'b0, 32'h400, 32'h480, 3, 32'h0, 0, 0);
        drop_read = -1;
        n_cmp++;
        if (done_err !== 1'b1 || done_words !== 1 || done_cyc !== 6) begin
            n_bad++; $display("FAIL rvalid_err: err=%b words=%0d done=%0d expected 1/1/6",
                              done_err, done_words, done_cyc);
        end
        n_cmp++;
        if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected 1", err_o); end
        run_cmd(1'b1, 32'h0, 32'h600, 0, 32'h0, 0, 0);
        n_cmp++;
        if (done_err !== 1'b0 || done_words !== 0) begin
            n_bad++; $display("FAIL err_clear: err=%b words=%0d expected 0/0", done_err, done_words);
        end
    endtask

    task automatic test_abort;
        preload(32'h700, 5);
        run_cmd(1'b0, 32'h700, 32'h780, 5, 32'h0, 5, 0);
        n_cmp++;
        if (done_cyc !== 6 || done_words !== 1 || last_req !== 4 || done_err !== 1'b0) begin
            n_bad++; $display("FAIL abort_wait: done=%0d words=%0d last_req=%0d err=%b expected 6/1/4/0",
                              done_cyc, done_words, last_req, done_err);
        end
        run_cmd(1'b0, 32'h700, 32'h780, 3, 32'h0, 4, 0);
        n_cmp++;
        if (done_cyc !== 5 || done_words !== 1 || last_req !== 3) begin
            n_bad++; $display("FAIL abort_rd: done=%0d words=%0d last_req=%0d expected 5/1/3",
                              done_cyc, done_words, last_req);
        end
        run_cmd(1'b1, 32'h0, 32'h800, 4, 32'h1234_5678, 2, 0);
        n_cmp++;
        if (done_cyc !== 3 || done_words !== 1 || last_req !== 1 || wr_addr_q.size() !== 1) begin
            n_bad++; $display("FAIL abort_wr: done=%0d words=%0d last_req=%0d expected 3/1/1",
                              done_cyc, done_words, last_req);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        preload(32'h900, 5);
        @(negedge clk_i);
        mode_i = 1'b0; src_addr_i = 32'h900; dst_addr_i = 32'h980; len_i = 16'd5; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i); start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i); #1;
        rst_i = 1'b0;
        n_cmp++;
        if ({busy_o, done_o, err_o, words_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 89'h0) begin
            n_bad++; $display("FAIL reset_mid: busy=%b done=%b words=%0d req=%b expected all 0",
                              busy_o, done_o, words_o, mem_req_o);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk_i); #1;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || mem_req_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL reset_quiet: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 3; t++) begin
            logic [31:0] d, f;
            int len;
            len = $urandom_range(2, 6);
            d = 32'h2000 + 32'(4 * $urandom_range(0, 63));
            f = $urandom;
            model_cmd(1'b1, 32'h0, d, len, f);
            run_cmd(1'b1, 32'h0, d, len, f, 0, 2);
            n_cmp++;
            if (done_cyc !== exp_done || done_words !== len || wr_addr_q != exp_addr_q
                || wr_data_q != exp_data_q || !post_ok) begin
                n_bad++; $display("FAIL b2b[%0d]: done=%0d words=%0d writes=%0d expected %0d/%0d/%0d",
                                  t, done_cyc, done_words, wr_addr_q.size(), exp_done, len, exp_addr_q.size());
            end
        end
    endtask

    initial begin
        test_reset;
        test_copy;
        test_fill;
        test_len_zero;
        test_wrap;
        test_rvalid_error;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
